// File: rtl/blob_stats_reader.sv
// blob_stats_reader: accumulates per-label area/bbox over a frame, then streams one record per surviving blob.
// Define BLOB_STATS_SUMS_EN to also accumulate and output per-label coordinate sums.
module blob_stats_reader #(
    parameter int HRES       = 320,
    parameter int VRES       = 180,
    parameter int NUM_LABELS = 64,
    parameter int MIN_AREA   = 10
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] label_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    input  logic        frame_end_in,
    output logic        blob_valid_out,
    input  logic        blob_ready_in,
    output logic [15:0] blob_label_out,
    output logic [31:0] blob_area_out,
    output logic [10:0] blob_min_x_out,
    output logic [10:0] blob_max_x_out,
    output logic [9:0]  blob_min_y_out,
    output logic [9:0]  blob_max_y_out,
    output logic [31:0] blob_sum_x_out,
    output logic [31:0] blob_sum_y_out,
    output logic        frame_done_out,
    output logic [15:0] blob_count_out,
    output logic        busy_out,
    output logic        overflow_out
);
    localparam int IW = $clog2(NUM_LABELS);
    localparam logic [10:0]   H_LIM = 11'(HRES);
    localparam logic [9:0]    V_LIM = 10'(VRES);
    localparam logic [15:0]   L_LIM = 16'(NUM_LABELS);
    localparam logic [31:0]   A_MIN = 32'(MIN_AREA);
    localparam logic [IW-1:0] LAST  = IW'(NUM_LABELS - 1);

    typedef enum logic [1:0] {ACCUM, SCAN, EMIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   cnt_q, cnt_d, count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   rec_label_q, rec_label_d;
    logic [31:0]   rec_area_q, rec_area_d;
    logic [10:0]   rec_min_x_q, rec_min_x_d, rec_max_x_q, rec_max_x_d;
    logic [9:0]    rec_min_y_q, rec_min_y_d, rec_max_y_q, rec_max_y_d;

    logic [31:0] area_q  [NUM_LABELS];
    logic [10:0] min_x_q [NUM_LABELS];
    logic [10:0] max_x_q [NUM_LABELS];
    logic [9:0]  min_y_q [NUM_LABELS];
    logic [9:0]  max_y_q [NUM_LABELS];

    logic          pix_ok, bad_label, wr_en, wr_clr, last;
    logic [IW-1:0] pix_idx, wr_idx;
    logic [31:0]   wr_area;
    logic [10:0]   wr_min_x, wr_max_x;
    logic [9:0]    wr_min_y, wr_max_y;

    assign pix_idx   = label_in[IW-1:0];
    assign bad_label = valid_in && label_in >= L_LIM;
    assign pix_ok    = valid_in && label_in != 16'd0 && label_in < L_LIM && hcount_in < H_LIM && vcount_in < V_LIM;
    assign last      = idx_q == LAST;

    // Single write port: either a pixel update (read-modify-write in one cycle, so no hazard) or a scan clear.
    assign wr_area  = wr_clr ? '0 : area_q[pix_idx] + 32'd1;
    assign wr_min_x = wr_clr ? '1 : (hcount_in < min_x_q[pix_idx] ? hcount_in : min_x_q[pix_idx]);
    assign wr_max_x = wr_clr ? '0 : (hcount_in > max_x_q[pix_idx] ? hcount_in : max_x_q[pix_idx]);
    assign wr_min_y = wr_clr ? '1 : (vcount_in < min_y_q[pix_idx] ? vcount_in : min_y_q[pix_idx]);
    assign wr_max_y = wr_clr ? '0 : (vcount_in > max_y_q[pix_idx] ? vcount_in : max_y_q[pix_idx]);

`ifdef BLOB_STATS_SUMS_EN
    logic [31:0] sum_x_q [NUM_LABELS];
    logic [31:0] sum_y_q [NUM_LABELS];
    logic [31:0] rec_sum_x_q, rec_sum_x_d, rec_sum_y_q, rec_sum_y_d;
    logic [31:0] wr_sum_x, wr_sum_y;

    assign wr_sum_x = wr_clr ? '0 : sum_x_q[pix_idx] + 32'(hcount_in);
    assign wr_sum_y = wr_clr ? '0 : sum_y_q[pix_idx] + 32'(vcount_in);

    always_comb begin
        rec_sum_x_d = rec_sum_x_q;
        rec_sum_y_d = rec_sum_y_q;
        if (state_q == SCAN && area_q[idx_q] >= A_MIN) begin
            rec_sum_x_d = sum_x_q[idx_q];
            rec_sum_y_d = sum_y_q[idx_q];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rec_sum_x_q <= '0;
            rec_sum_y_q <= '0;
            for (int i = 0; i < NUM_LABELS; i++) begin
                sum_x_q[i] <= '0;
                sum_y_q[i] <= '0;
            end
        end else begin
            rec_sum_x_q <= rec_sum_x_d;
            rec_sum_y_q <= rec_sum_y_d;
            if (wr_en) begin
                sum_x_q[wr_idx] <= wr_sum_x;
                sum_y_q[wr_idx] <= wr_sum_y;
            end
        end
    end

    assign blob_sum_x_out = rec_sum_x_q;
    assign blob_sum_y_out = rec_sum_y_q;
`else
    assign blob_sum_x_out = '0;
    assign blob_sum_y_out = '0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        rec_label_d = rec_label_q;
        rec_area_d  = rec_area_q;
        rec_min_x_d = rec_min_x_q;
        rec_max_x_d = rec_max_x_q;
        rec_min_y_d = rec_min_y_q;
        rec_max_y_d = rec_max_y_q;
        wr_en       = 1'b0;
        wr_clr      = 1'b0;
        wr_idx      = idx_q;
        case (state_q)
            ACCUM: begin
                ovf_d  = ovf_q | bad_label;
                wr_en  = pix_ok;
                wr_idx = pix_idx;
                if (frame_end_in) begin
                    state_d = SCAN;
                    idx_d   = IW'(1);
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                ovf_d = ovf_q | valid_in;
                if (area_q[idx_q] >= A_MIN) begin
                    state_d     = EMIT;
                    rec_label_d = 16'(idx_q);
                    rec_area_d  = area_q[idx_q];
                    rec_min_x_d = min_x_q[idx_q];
                    rec_max_x_d = max_x_q[idx_q];
                    rec_min_y_d = min_y_q[idx_q];
                    rec_max_y_d = max_y_q[idx_q];
                end else begin
                    wr_en   = 1'b1;
                    wr_clr  = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    state_d = last ? DONE : SCAN;
                    count_d = last ? cnt_q : count_q;
                end
            end
            EMIT: begin
                ovf_d = ovf_q | valid_in;
                if (blob_ready_in) begin
                    wr_en   = 1'b1;
                    wr_clr  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    idx_d   = idx_q + 1'b1;
                    state_d = last ? DONE : SCAN;
                    count_d = last ? cnt_q + 16'd1 : count_q;
                end
            end
            default: begin
                ovf_d   = 1'b0;
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ACCUM;
            idx_q       <= '0;
            cnt_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            rec_label_q <= '0;
            rec_area_q  <= '0;
            rec_min_x_q <= '0;
            rec_max_x_q <= '0;
            rec_min_y_q <= '0;
            rec_max_y_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            rec_label_q <= rec_label_d;
            rec_area_q  <= rec_area_d;
            rec_min_x_q <= rec_min_x_d;
            rec_max_x_q <= rec_max_x_d;
            rec_min_y_q <= rec_min_y_d;
            rec_max_y_q <= rec_max_y_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                area_q[i]  <= '0;
                min_x_q[i] <= '1;
                max_x_q[i] <= '0;
                min_y_q[i] <= '1;
                max_y_q[i] <= '0;
            end
        end else if (wr_en) begin
            area_q[wr_idx]  <= wr_area;
            min_x_q[wr_idx] <= wr_min_x;
            max_x_q[wr_idx] <= wr_max_x;
            min_y_q[wr_idx] <= wr_min_y;
            max_y_q[wr_idx] <= wr_max_y;
        end
    end

    assign blob_valid_out = state_q == EMIT;
    assign frame_done_out = state_q == DONE;
    assign busy_out       = state_q != ACCUM;
    assign blob_count_out = count_q;
    assign overflow_out   = ovf_q;
    assign blob_label_out = rec_label_q;
    assign blob_area_out  = rec_area_q;
    assign blob_min_x_out = rec_min_x_q;
    assign blob_max_x_out = rec_max_x_q;
    assign blob_min_y_out = rec_min_y_q;
    assign blob_max_y_out = rec_max_y_q;
endmodule

// File: tb/tb_blob_stats_reader.sv
// tb_blob_stats_reader: randomized and directed frames checked against a per-label statistics model.
module tb_blob_stats_reader;
    logic        clk_in = 1'b0, rst_in = 1'b1;
    logic [15:0] label_in = '0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        valid_in = 1'b0, frame_end_in = 1'b0, blob_ready_in = 1'b1;
    logic        blob_valid_out, frame_done_out, busy_out, overflow_out;
    logic [15:0] blob_label_out, blob_count_out;
    logic [31:0] blob_area_out, blob_sum_x_out, blob_sum_y_out;
    logic [10:0] blob_min_x_out, blob_max_x_out;
    logic [9:0]  blob_min_y_out, blob_max_y_out;

    blob_stats_reader dut (
        .clk_in(clk_in), .rst_in(rst_in), .label_in(label_in), .hcount_in(hcount_in),
        .vcount_in(vcount_in), .valid_in(valid_in), .frame_end_in(frame_end_in),
        .blob_valid_out(blob_valid_out), .blob_ready_in(blob_ready_in),
        .blob_label_out(blob_label_out), .blob_area_out(blob_area_out),
        .blob_min_x_out(blob_min_x_out), .blob_max_x_out(blob_max_x_out),
        .blob_min_y_out(blob_min_y_out), .blob_max_y_out(blob_max_y_out),
        .blob_sum_x_out(blob_sum_x_out), .blob_sum_y_out(blob_sum_y_out),
        .frame_done_out(frame_done_out), .blob_count_out(blob_count_out),
        .busy_out(busy_out), .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef logic [153:0] rec_t;

    int          tests = 0, fails = 0;
    logic [15:0] px_l[$];
    logic [10:0] px_x[$];
    logic [9:0]  px_y[$];
    bit          px_v[$];
    rec_t        got_q[$], exp_q[$];
    int          lat, ready_mode, stable_cnt, unstable;
    logic [15:0] cnt_obs;
    logic        ovf_done, exp_ovf;
    bit          busy_px;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic rec_t dut_rec();
        return {blob_label_out, blob_area_out, blob_min_x_out, blob_max_x_out,
                blob_min_y_out, blob_max_y_out, blob_sum_x_out, blob_sum_y_out};
    endfunction

    function automatic logic [173:0] all_out();
        return {blob_valid_out, dut_rec(), frame_done_out, blob_count_out, busy_out, overflow_out};
    endfunction

    function automatic rec_t mk_rec(int l, int a, int x0, int x1, int y0, int y1, int sx, int sy);
`ifdef BLOB_STATS_SUMS_EN
        return {16'(l), 32'(a), 11'(x0), 11'(x1), 10'(y0), 10'(y1), 32'(sx), 32'(sy)};
`else
        return {16'(l), 32'(a), 11'(x0), 11'(x1), 10'(y0), 10'(y1), 64'd0};
`endif
    endfunction

    task automatic clear_px();
        px_l.delete(); px_x.delete(); px_y.delete(); px_v.delete();
        busy_px = 0;
    endtask

    task automatic add_px(int l, int x, int y, bit v);
        px_l.push_back(16'(l)); px_x.push_back(11'(x)); px_y.push_back(10'(y)); px_v.push_back(v);
    endtask

    task automatic add_rect(int l, int x0, int y0, int w, int h);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++) add_px(l, x, y, 1);
    endtask

    // Reference: per-label tallies from the pixel list, records for labels 1..63 with area >= 10.
    task automatic build_expected();
        int a[64], mnx[64], mxx[64], mny[64], mxy[64], sx[64], sy[64];
        int l;
        exp_q.delete();
        exp_ovf = busy_px;
        for (int i = 0; i < 64; i++) begin
            a[i] = 0; mnx[i] = 2047; mxx[i] = 0; mny[i] = 1023; mxy[i] = 0; sx[i] = 0; sy[i] = 0;
        end
        foreach (px_l[i]) begin
            if (!px_v[i]) continue;
            if (px_l[i] >= 64) begin exp_ovf = 1; continue; end
            if (px_l[i] == 0 || px_x[i] >= 320 || px_y[i] >= 180) continue;
            l = int'(px_l[i]);
            a[l]++;
            sx[l] += int'(px_x[i]);
            sy[l] += int'(px_y[i]);
            if (int'(px_x[i]) < mnx[l]) mnx[l] = int'(px_x[i]);
            if (int'(px_x[i]) > mxx[l]) mxx[l] = int'(px_x[i]);
            if (int'(px_y[i]) < mny[l]) mny[l] = int'(px_y[i]);
            if (int'(px_y[i]) > mxy[l]) mxy[l] = int'(px_y[i]);
        end
        for (int i = 1; i < 64; i++)
            if (a[i] >= 10) exp_q.push_back(mk_rec(i, a[i], mnx[i], mxx[i], mny[i], mxy[i], sx[i], sy[i]));
    endtask

    task automatic send_pixels();
        foreach (px_l[i]) begin
            label_in = px_l[i]; hcount_in = px_x[i]; vcount_in = px_y[i]; valid_in = px_v[i];
            step();
        end
        valid_in = 0;
    endtask

    // Drives a frame, collects emitted records; lat counts cycles from frame_end_in to frame_done_out.
    task automatic run_frame();
        bit   holding = 0;
        rec_t held = '0;
        int   vcycles = 0;
        send_pixels();
        got_q.delete();
        lat = -1; stable_cnt = 0; unstable = 0;
        blob_ready_in = (ready_mode == 0);
        frame_end_in = 1;
        for (int k = 1; k <= 3000; k++) begin
            step();
            frame_end_in = 0;
            valid_in = busy_px && k == 3;
            label_in = 16'd2; hcount_in = 11'd1; vcount_in = 10'd1;
            if (frame_done_out) begin
                lat = k; cnt_obs = blob_count_out; ovf_done = overflow_out;
                break;
            end
            if (blob_valid_out) begin
                if (holding) begin
                    if (dut_rec() !== held) unstable++;
                    else stable_cnt++;
                end
                vcycles++;
                blob_ready_in = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : vcycles > 10;
                if (blob_ready_in) begin
                    got_q.push_back(dut_rec()); holding = 0; vcycles = 0;
                end else begin
                    holding = 1; held = dut_rec();
                end
            end else holding = 0;
        end
        valid_in = 0;
        blob_ready_in = 1;
        if (lat < 0) begin
            tests++; fails++;
            $display("FAIL frame_done timeout: no frame_done_out within 3000 cycles");
        end
        step();
    endtask

    task automatic test_reset();
        tests++;
        if (all_out() !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h, want 0", all_out());
        end
        step();
        rst_in = 0;
        step();
    endtask

    task automatic test_single_blob();
        clear_px(); add_rect(1, 10, 20, 4, 4);
        ready_mode = 0; run_frame(); build_expected();
        tests++;
        if (got_q.size() != 1) begin fails++; $display("FAIL single_count: got %0d records, want 1", got_q.size()); end
        else begin
            tests++;
            if (got_q[0] !== mk_rec(1, 16, 10, 13, 20, 23, 184, 344)) begin
                fails++; $display("FAIL single_rec: got %h, want %h", got_q[0], mk_rec(1, 16, 10, 13, 20, 23, 184, 344));
            end
            tests++;
            if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL single_model: got %h, want %h", got_q[0], exp_q[0]); end
        end
        tests++;
        if (cnt_obs !== 16'd1) begin fails++; $display("FAIL single_blob_count: got %0d, want 1", cnt_obs); end
        tests++;
        if (lat != 65) begin fails++; $display("FAIL single_latency: got %0d, want 65", lat); end
    endtask

    task automatic test_two_blobs();
        clear_px(); add_rect(2, 50, 60, 5, 5); add_rect(3, 100, 100, 5, 1);
        ready_mode = 0; run_frame(); build_expected();
        tests++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0][153:138] !== 16'd2) begin
            fails++; $display("FAIL two_blobs_rec: got %0d records first %h, want 1 record %h", got_q.size(), got_q.size() ? got_q[0] : '0, exp_q[0]);
        end
        tests++;
        if (cnt_obs !== 16'd1) begin fails++; $display("FAIL two_blobs_count: got %0d, want 1", cnt_obs); end
        clear_px(); add_rect(3, 100, 100, 5, 1);
        run_frame();
        tests++;
        if (got_q.size() != 0 || cnt_obs !== 16'd0) begin
            fails++; $display("FAIL table_cleared: got %0d records count %0d, want 0 and 0", got_q.size(), cnt_obs);
        end
    endtask

    task automatic test_backpressure();
        clear_px(); add_rect(4, 0, 0, 3, 4);
        ready_mode = 2; run_frame(); build_expected();
        tests++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            fails++; $display("FAIL bp_rec: got %0d records, want 1 record %h", got_q.size(), exp_q[0]);
        end
        tests++;
        if (stable_cnt != 10 || unstable != 0) begin
            fails++; $display("FAIL bp_stable: got %0d stable %0d changed, want 10 and 0", stable_cnt, unstable);
        end
        tests++;
        if (cnt_obs !== 16'd1) begin fails++; $display("FAIL bp_count: got %0d, want 1", cnt_obs); end
    endtask

    task automatic test_overflow();
        label_in = 16'd64; hcount_in = 11'd5; vcount_in = 10'd5; valid_in = 1;
        step();
        valid_in = 0;
        tests++;
        if (overflow_out !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b, want 1", overflow_out); end
        clear_px(); add_rect(2, 5, 5, 4, 3); busy_px = 1;
        ready_mode = 0; run_frame(); build_expected();
        tests++;
        if (got_q.size() != 1 || got_q[0] !== mk_rec(2, 12, 5, 8, 5, 7, 26 * 3, 18 * 4)) begin
            fails++; $display("FAIL ovf_rec: got %0d records first %h, want %h", got_q.size(), got_q.size() ? got_q[0] : '0, mk_rec(2, 12, 5, 8, 5, 7, 78, 72));
        end
        tests++;
        if (ovf_done !== 1'b1) begin fails++; $display("FAIL ovf_at_done: got %b, want 1", ovf_done); end
        tests++;
        if (overflow_out !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got %b, want 0", overflow_out); end
    endtask

    task automatic test_empty();
        clear_px();
        for (int i = 0; i < 20; i++) add_px(0, i, i, 1);
        ready_mode = 0; run_frame();
        tests++;
        if (got_q.size() != 0 || cnt_obs !== 16'd0) begin
            fails++; $display("FAIL empty_records: got %0d records count %0d, want 0 and 0", got_q.size(), cnt_obs);
        end
        tests++;
        if (lat != 64) begin fails++; $display("FAIL empty_latency: got %0d, want 64", lat); end
        tests++;
        if (ovf_done !== 1'b0) begin fails++; $display("FAIL empty_ovf: got %b, want 0", ovf_done); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            clear_px();
            for (int r = $urandom_range(1, 6); r > 0; r--)
                add_rect($urandom_range(1, 63), $urandom_range(0, 318), $urandom_range(0, 178), $urandom_range(1, 6), $urandom_range(1, 6));
            for (int n = 0; n < 20; n++) begin
                case ($urandom_range(0, 5))
                    0: add_px(0, $urandom_range(0, 319), $urandom_range(0, 179), 1);
                    1: if (f % 2 == 0) add_px($urandom_range(64, 9000), $urandom_range(0, 319), $urandom_range(0, 179), 1);
                    2: add_px($urandom_range(1, 63), $urandom_range(320, 2047), $urandom_range(0, 179), 1);
                    3: add_px($urandom_range(1, 63), $urandom_range(0, 319), $urandom_range(180, 1023), 1);
                    default: add_px($urandom_range(0, 9000), $urandom_range(0, 319), $urandom_range(0, 179), 0);
                endcase
            end
            ready_mode = 1; run_frame(); build_expected();
            tests++;
            if (got_q.size() != exp_q.size()) begin
                fails++; $display("FAIL rand_count f%0d: got %0d records, want %0d", f, got_q.size(), exp_q.size());
            end else
                foreach (exp_q[i]) begin
                    tests++;
                    if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_rec f%0d #%0d: got %h, want %h", f, i, got_q[i], exp_q[i]); end
                end
            tests++;
            if (cnt_obs !== 16'(exp_q.size()) || ovf_done !== exp_ovf) begin
                fails++; $display("FAIL rand_status f%0d: got count %0d ovf %b, want %0d %b", f, cnt_obs, ovf_done, exp_q.size(), exp_ovf);
            end
        end
    endtask

    task automatic test_reset_emit();
        bit found = 0;
        clear_px(); add_rect(1, 10, 20, 4, 4); add_rect(7, 30, 30, 4, 4);
        send_pixels();
        blob_ready_in = 0;
        frame_end_in = 1;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            frame_end_in = 0;
            found = blob_valid_out;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL emit_reach: got no blob_valid_out, want a record"); end
        #2 rst_in = 1;
        #1;
        tests++;
        if (all_out() !== '0) begin fails++; $display("FAIL reset_in_emit: got %h, want 0", all_out()); end
        step();
        rst_in = 0;
        step();
        clear_px(); add_rect(5, 40, 40, 4, 3);
        ready_mode = 0; run_frame(); build_expected();
        tests++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0][137:106] !== 32'd12) begin
            fails++; $display("FAIL post_reset_frame: got %0d records first %h, want 1 record %h", got_q.size(), got_q.size() ? got_q[0] : '0, exp_q[0]);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_blob();
        test_two_blobs();
        test_backpressure();
        test_overflow();
        test_empty();
        test_random();
        test_reset_emit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/blob_stats_reader.md
Name: blob_stats_reader

Overview:
- Consumes the labeled pixel stream from the connected-components stage: label, hcount, vcount and valid.
- Accumulates per-label statistics over one frame: area, bounding box and coordinate sums.
- At frame end, scans the label table and streams one record per surviving blob over a valid/ready interface to downstream tracking and overlay logic.
- Clears the table for the next frame.

Parameters:
- HRES, 320, horizontal resolution; hcount values >= HRES are ignored.
- VRES, 180, vertical resolution; vcount values >= VRES are ignored.
- NUM_LABELS, 64, table depth; valid labels are 1..NUM_LABELS-1, label 0 is background.
- MIN_AREA, 10, minimum pixel count for a blob record to be emitted.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-high
- label_in  input  16  pixel label, 0 = background
- hcount_in  input  11  pixel x
- vcount_in  input  10  pixel y
- valid_in  input  1  pixel qualifier
- frame_end_in  input  1  one-cycle pulse after the last pixel of a frame
- blob_valid_out  output  1  record valid
- blob_ready_in  input  1  downstream accepts record
- blob_label_out  output  16  label of record
- blob_area_out  output  32  pixel count
- blob_min_x_out  output  11  bounding box
- blob_max_x_out  output  11  bounding box
- blob_min_y_out  output  10  bounding box
- blob_max_y_out  output  10  bounding box
- blob_sum_x_out  output  32  sum of x (feature-gated)
- blob_sum_y_out  output  32  sum of y (feature-gated)
- frame_done_out  output  1  one-cycle pulse, scan complete
- blob_count_out  output  16  records emitted in the last scan; held until the next frame_done_out
- busy_out  output  1  high outside ACCUM
- overflow_out  output  1  sticky per frame: out-of-range label seen, or pixel dropped while busy

Behaviour:
- Reset values: all outputs 0; state ACCUM; table entries area=0, min_x=2047, max_x=0, min_y=1023, max_y=0, sums=0.
- States: ACCUM, SCAN, EMIT, DONE.
- ACCUM, table update:
  - Applies to a pixel with valid_in=1, label_in != 0, label_in < NUM_LABELS, and hcount/vcount in range.
  - The entry is updated at the next clock edge: area+1, min/max updated, sums incremented.
  - Back-to-back pixels with the same label must accumulate correctly every cycle (read-modify-write with no hazard).
- ACCUM, rejected pixels:
  - Label >= NUM_LABELS: pixel ignored, overflow_out set.
  - Label 0 or out-of-range coordinates: ignored silently.
- ACCUM, frame end:
  - frame_end_in=1 moves to SCAN, with index=1, at the next edge.
  - A pixel presented in the same cycle as frame_end_in is still accumulated.
- SCAN:
  - One index per cycle.
  - If area[index] >= MIN_AREA: load the record registers, go to EMIT, blob_valid_out=1 from the next cycle.
  - Otherwise: clear the entry and advance the index.
  - After index NUM_LABELS-1 is processed, go to DONE.
- EMIT:
  - Record outputs are held stable while blob_valid_out=1 and blob_ready_in=0.
  - On a valid&&ready cycle: increment blob_count, clear the entry, return to SCAN at index+1 (or DONE if it was the last index).
  - blob_valid_out drops the cycle after acceptance.
  - Recommended to be glitch-free; blob_ready_in may be tied high.
- DONE:
  - frame_done_out=1 for one cycle; blob_count_out updated in the same cycle.
  - overflow_out cleared, then back to ACCUM.
- Minimum scan latency with no surviving blobs: frame_end_in at cycle T gives frame_done_out at T+NUM_LABELS.
- Pixels arriving while busy_out=1 are dropped and set overflow_out.
- frame_end_in while busy is ignored.
- Arithmetic: area and sums are 32-bit; no saturation needed at the given resolutions.
- Reset mid-SCAN or mid-EMIT:
  - Immediate return to reset values; the table is reinitialised.
  - No frame_done_out is issued.

Optional Feature:
- Macro BLOB_STATS_SUMS_EN.
- Defined: sum_x/sum_y are accumulated per entry and driven on blob_sum_x_out/blob_sum_y_out, for downstream centroid computation.
- Undefined: no sum storage is instantiated; both ports are driven to constant 0. All other behaviour is unchanged.

Test Plan:
- Single blob, 4x4 of label 1 at x=10..13, y=20..23, then frame_end, blob_ready_in=1:
  - One record: label 1, area 16, x 10..13, y 20..23, sum_x 184, sum_y 344 (sums 0 without the macro).
  - frame_done_out at T+64; blob_count_out=1.
- Two blobs, label 2 with area 25 and label 3 with area 5:
  - Only label 2 emitted; blob_count_out=1.
  - Next frame containing label 3 with 5 pixels also gives no record, proving the table was cleared.
- Backpressure: blob_ready_in low for 10 cycles while a record is valid -> outputs stable for all 10 cycles; exactly one acceptance; count correct.
- Pixel with label 64, plus a pixel during SCAN -> neither pixel is counted; overflow_out=1 until frame_done_out, then 0.
- Empty frame (all label 0) -> no blob_valid_out; frame_done_out exactly 64 cycles after frame_end_in; blob_count_out=0.
- Reset asserted during EMIT -> all outputs 0, state ACCUM; a fresh frame of 12 pixels of label 5 gives area 12, with no stale data.
